// File: rtl/cb_rr_enq_arbiter.sv
// Round-robin enqueue arbiter in front of a shared circular buffer.
// NUM_REQ producers compete for one write slot per cycle; one consumer drains in FIFO order.
`timescale 1ns/1ps
module cb_rr_enq_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REQ         = 4,
  parameter int LOG_NUM_REQ     = $clog2(NUM_REQ),
  parameter int NUM_ENTRIES     = 4,
  parameter int LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES)
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          deq_valid,
  output logic [DATA_WIDTH-1:0]         deq_data,
  output logic [LOG_NUM_REQ-1:0]        deq_src,
  input  logic                          deq_ready,
  output logic [LOG_NUM_ENTRIES:0]      count
);

  localparam int PW = LOG_NUM_ENTRIES + 1;

  logic [DATA_WIDTH-1:0]      r_data [NUM_ENTRIES];
  logic [LOG_NUM_REQ-1:0]     r_src  [NUM_ENTRIES];
  logic [PW-1:0]              r_enq_ptr;
  logic [PW-1:0]              r_deq_ptr;
  logic [LOG_NUM_REQ-1:0]     r_rr_ptr;

  logic [LOG_NUM_ENTRIES-1:0] w_enq_idx;
  logic [LOG_NUM_ENTRIES-1:0] w_deq_idx;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_deq_fire;
  logic                       w_space;
  logic                       w_found;
  logic [LOG_NUM_REQ-1:0]     w_gidx;
  logic                       w_enq_fire;
  logic [LOG_NUM_REQ-1:0]     w_rr_next;
  logic [DATA_WIDTH-1:0]      w_enq_data;

  assign w_enq_idx  = r_enq_ptr[LOG_NUM_ENTRIES-1:0];
  assign w_deq_idx  = r_deq_ptr[LOG_NUM_ENTRIES-1:0];
  assign w_empty    = (r_enq_ptr == r_deq_ptr);
  assign w_full     = (w_enq_idx == w_deq_idx) && (r_enq_ptr[PW-1] != r_deq_ptr[PW-1]);
  assign count      = r_enq_ptr - r_deq_ptr;

  // Handshakes: a transfer fires on a cycle where valid & ready are both high at posedge.
  // req_ready is a combinational function of req_valid; deq_valid never depends on deq_ready.
  assign deq_valid  = !w_empty;
  assign deq_data   = r_data[w_deq_idx];
  assign deq_src    = r_src[w_deq_idx];
  assign w_deq_fire = deq_valid & deq_ready;
  assign w_space    = !w_full | w_deq_fire;

  always_comb begin
    logic [LOG_NUM_REQ-1:0] v_idx;
    w_found = 1'b0;
    w_gidx  = '0;
    v_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = LOG_NUM_REQ'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gidx  = v_idx;
      end
    end
  end

  // Gated by nRST so the grant collapses as soon as reset is asserted.
  assign w_enq_fire = nRST & w_space & w_found;
  assign req_ready  = w_enq_fire ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gidx) : '0;
  assign w_rr_next  = LOG_NUM_REQ'((int'(w_gidx) + 1) % NUM_REQ);
  assign w_enq_data = req_data[w_gidx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_rr_ptr  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_data[i] <= '0;
        r_src[i]  <= '0;
      end
    end else begin
      if (w_enq_fire) begin
        r_data[w_enq_idx] <= w_enq_data;
        r_src[w_enq_idx]  <= w_gidx;
        r_enq_ptr         <= r_enq_ptr + PW'(1);
        r_rr_ptr          <= w_rr_next;
      end
      if (w_deq_fire) begin
        r_deq_ptr <= r_deq_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cb_rr_enq_arbiter.sv
// Bench for cb_rr_enq_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_cb_rr_enq_arbiter;

  logic         CLK;
  logic         nRST;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         deq_valid;
  logic [31:0]  deq_data;
  logic [1:0]   deq_src;
  logic         deq_ready;
  logic [2:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  cb_rr_enq_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_src(deq_src),
    .deq_ready(deq_ready), .count(count)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nRST      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    deq_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // vector table
  typedef struct {
    logic         do_rst;
    logic [3:0]   valid;
    logic [127:0] data;
    logic         dr;
    logic [3:0]   e_rdy;
    logic         e_dv;
    logic [31:0]  e_dd;
    logic [1:0]   e_ds;
    logic [2:0]   e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [127:0] d, logic dr,
                              logic [3:0] rdy, logic dv, logic [31:0] dd, logic [1:0] ds,
                              logic [2:0] cnt);
    vec_t r;
    r.do_rst = rst; r.valid = v; r.data = d; r.dr = dr;
    r.e_rdy = rdy; r.e_dv = dv; r.e_dd = dd; r.e_ds = ds; r.e_cnt = cnt;
    return r;
  endfunction

  logic [31:0] exp_q[$];
  logic [1:0]  src_q[$];

  initial begin
    logic [127:0] d_a, d_c, d_d;
    logic [31:0]  rd [4];
    int           rr;
    int           g;
    bit           space;

    d_a = {32'h0, 32'hB2, 32'hA1, 32'h0};
    d_c = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    d_d = {32'h0, 32'h0, 32'h0, 32'hD0};

    // Segment A: idle after reset, two-producer grant order, rr pointer continuation
    vecs.push_back(mk(1, 4'b0000, '0,  1, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0110, d_a, 0, 4'b0010, 0, 32'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0110, d_a, 0, 4'b0100, 1, 32'hA1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, '0,  0, 4'b0000, 1, 32'hA1, 1, 2));
    vecs.push_back(mk(0, 4'b1111, d_c, 0, 4'b1000, 1, 32'hA1, 1, 2));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hA1, 1, 3));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hB2, 2, 2));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hC3, 3, 1));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 0, 32'h0,  0, 0));
    // Segment B: fill to full from rr=0, then enqueue into a full buffer while dequeuing
    vecs.push_back(mk(1, 4'b1111, d_c, 0, 4'b0001, 0, 32'h0,  0, 0));
    vecs.push_back(mk(0, 4'b1111, d_c, 0, 4'b0010, 1, 32'hC0, 0, 1));
    vecs.push_back(mk(0, 4'b1111, d_c, 0, 4'b0100, 1, 32'hC0, 0, 2));
    vecs.push_back(mk(0, 4'b1111, d_c, 0, 4'b1000, 1, 32'hC0, 0, 3));
    vecs.push_back(mk(0, 4'b1111, d_c, 0, 4'b0000, 1, 32'hC0, 0, 4));
    vecs.push_back(mk(0, 4'b0001, d_d, 1, 4'b0001, 1, 32'hC0, 0, 4));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hC1, 1, 4));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hC2, 2, 3));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hC3, 3, 2));
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 1, 32'hD0, 0, 1));
    // Empty again: head slot 1 still holds stale C1 from source 1
    vecs.push_back(mk(0, 4'b0000, '0,  1, 4'b0000, 0, 32'hC1, 1, 0));

    nRST = 1'b1; req_valid = '0; req_data = '0; deq_ready = 1'b0;
    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      deq_ready = vecs[i].dr;
      #1;
      check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d_deq_valid", i), 64'(deq_valid), 64'(vecs[i].e_dv));
      check($sformatf("vec%0d_deq_data", i),  64'(deq_data),  64'(vecs[i].e_dd));
      check($sformatf("vec%0d_deq_src", i),   64'(deq_src),   64'(vecs[i].e_ds));
      check($sformatf("vec%0d_count", i),     64'(count),     64'(vecs[i].e_cnt));
      next_cycle();
    end

    // Streaming through one producer across pointer wrap
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'b0100;
      req_data  = {32'h0, 32'(k), 32'h0, 32'h0};
      deq_ready = 1'b1;
      #1;
      check($sformatf("stream%0d_req_ready", k), 64'(req_ready), 64'h4);
      if (k == 0) begin
        check("stream0_deq_valid", 64'(deq_valid), 64'h0);
        check("stream0_count", 64'(count), 64'h0);
      end else begin
        check($sformatf("stream%0d_deq_data", k), 64'(deq_data), 64'(k - 1));
        check($sformatf("stream%0d_deq_src", k), 64'(deq_src), 64'h2);
        check($sformatf("stream%0d_count", k), 64'(count), 64'h1);
      end
      next_cycle();
    end
    req_valid = '0;
    #1;
    check("stream_last_data", 64'(deq_data), 64'h9);
    check("stream_last_valid", 64'(deq_valid), 64'h1);
    next_cycle();
    check("stream_drained_count", 64'(count), 64'h0);
    check("stream_drained_valid", 64'(deq_valid), 64'h0);

    // Asynchronous reset in the middle of traffic
    do_reset();
    req_valid = 4'b0001;
    req_data  = {96'h0, 32'hE0};
    deq_ready = 1'b0;
    repeat (3) next_cycle();
    #1;
    check("midrst_pre_count", 64'(count), 64'h3);
    req_valid = 4'b1111;
    req_data  = d_c;
    #1 nRST = 1'b0;
    #1;
    check("midrst_deq_valid", 64'(deq_valid), 64'h0);
    check("midrst_count", 64'(count), 64'h0);
    check("midrst_req_ready", 64'(req_ready), 64'h0);
    check("midrst_deq_data", 64'(deq_data), 64'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    #1;
    check("midrst_first_grant", 64'(req_ready), 64'h1);
    next_cycle();

    // Randomized traffic against a queue model of the buffer
    do_reset();
    exp_q.delete();
    src_q.delete();
    rr = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) begin
        rd[j] = $urandom;
        req_data[j*32 +: 32] = rd[j];
      end
      deq_ready = ($urandom_range(0, 2) != 0);
      space = (exp_q.size() < 4) || (exp_q.size() > 0 && deq_ready);
      g = -1;
      if (space) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && req_valid[(rr + k) % 4]) g = (rr + k) % 4;
        end
      end
      #1;
      check("rnd_req_ready", 64'(req_ready), (g >= 0) ? (64'h1 << g) : 64'h0);
      check("rnd_deq_valid", 64'(deq_valid), 64'(exp_q.size() > 0));
      check("rnd_count", 64'(count), 64'(exp_q.size()));
      if (exp_q.size() > 0) begin
        check("rnd_deq_data", 64'(deq_data), 64'(exp_q[0]));
        check("rnd_deq_src", 64'(deq_src), 64'(src_q[0]));
      end
      next_cycle();
      if (exp_q.size() > 0 && deq_ready) begin
        void'(exp_q.pop_front());
        void'(src_q.pop_front());
      end
      if (g >= 0) begin
        exp_q.push_back(rd[g]);
        src_q.push_back(2'(g));
        rr = (g + 1) % 4;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
